// File: rtl/cache_pkg.sv
// Shared geometry, FSM encoding and victim selection for the 2-way, 2-set line-fill cache.
package cache_pkg;

  localparam int LINE_BYTES = 8;
  localparam int OFFSET_W   = 3;
  localparam int NUM_WAYS   = 2;
  localparam int NUM_SETS   = 2;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } fill_state_e;

  // An empty way is always preferred (way 0 first); only a full set falls back to LRU.
  function automatic logic pick_victim(input logic [NUM_WAYS-1:0] valid, input logic lru);
    if (!valid[0])      return 1'b0;
    else if (!valid[1]) return 1'b1;
    else                return lru;
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag, valid and LRU state for the line-fill cache, with combinational hit and victim lookup.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_set_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic             hit_way_o,
  output logic             victim_o,
  input  logic             touch_en_i,
  input  logic             touch_set_i,
  input  logic             touch_way_i,
  input  logic             commit_en_i,
  input  logic             commit_valid_i,
  input  logic             commit_set_i,
  input  logic             commit_way_i,
  input  logic [TAG_W-1:0] commit_tag_i,
  input  logic             flush_i
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] tag_q;
  logic [NUM_SETS-1:0]                          lru_q;

  // Compare both ways of the addressed set; at most one can match.
  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lookup_set_i][w] && (tag_q[lookup_set_i][w] == lookup_tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = w[0];
      end
    end
    victim_o = pick_victim(valid_q[lookup_set_i], lru_q[lookup_set_i]);
  end

  // Flush beats a same-cycle commit; lru always points away from the most recently used way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      lru_q   <= '0;
    end else begin
      if (flush_i)
        valid_q <= '0;
      else if (commit_en_i && commit_valid_i)
        valid_q[commit_set_i][commit_way_i] <= 1'b1;
      if (commit_en_i && commit_valid_i)
        tag_q[commit_set_i][commit_way_i] <= commit_tag_i;
      if (commit_en_i)
        lru_q[commit_set_i] <= ~commit_way_i;
      else if (touch_en_i)
        lru_q[touch_set_i] <= ~touch_way_i;
    end
  end

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Lookup FSM and line-fill engine: hit detection, CPU stall, byte-serial fill from program memory.
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic              cpu_stall,
  output logic              cache_rdline,
  output logic [2:0]        cache_rdoffset,
  output logic              cache_rdentry,
  output logic              cache_wrline,
  output logic [2:0]        cache_wroffset,
  output logic              cache_wrentry,
  output logic              cache_wren,
  output logic [7:0]        cache_wrdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - 4;

  fill_state_e             state_q, state_d;
  logic [OFFSET_W-1:0]     cnt_q;
  logic [ADDR_W-4:0]       line_q;
  logic                    victim_q;
  logic                    flushed_q;
  logic                    wren_q;
  logic [7:0]              wrdata_q;
  logic [OFFSET_W-1:0]     wroffset_q;
  logic                    wrline_q;
  logic                    wrentry_q;
  logic [CNT_W-1:0]        hit_cnt_q;
  logic [CNT_W-1:0]        miss_cnt_q;

  logic hit, hit_way, victim;
  logic start_fill, lookup_hit, beat_accept, last_beat, commit_en;

  assign lookup_hit  = (state_q == LOOKUP) && cpu_req && hit;
  assign start_fill  = (state_q == LOOKUP) && cpu_req && !hit && !flush;
  assign beat_accept = (state_q == FETCH) && !wren_q && mem_valid;
  assign last_beat   = (state_q == FETCH) && wren_q && (cnt_q == 3'd7);

  cache_tag_store #(.TAG_W(TAG_W)) u_tags (
    .clk            (clk),
    .reset          (reset),
    .lookup_set_i   (cpu_addr[3]),
    .lookup_tag_i   (cpu_addr[ADDR_W-1:4]),
    .hit_o          (hit),
    .hit_way_o      (hit_way),
    .victim_o       (victim),
    .touch_en_i     (lookup_hit),
    .touch_set_i    (cpu_addr[3]),
    .touch_way_i    (hit_way),
    .commit_en_i    (commit_en),
    .commit_valid_i (!flushed_q && !flush),
    .commit_set_i   (line_q[0]),
    .commit_way_i   (victim_q),
    .commit_tag_i   (line_q[ADDR_W-4:1]),
    .flush_i        (flush)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOOKUP;
    else       state_q <= state_d;
  end

  // Next state: a fill leaves FETCH only after the write of byte 7 has been presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOOKUP:  if (start_fill) state_d = FETCH;
      FETCH:   if (last_beat)  state_d = COMMIT;
      COMMIT:  state_d = LOOKUP;
      default: state_d = LOOKUP;
    endcase
  end

  // Outputs: one outstanding memory request, suppressed during the write cycle of each byte.
  always_comb begin
    cpu_stall = (state_q != LOOKUP) || (cpu_req && !hit);
    mem_req   = (state_q == FETCH) && !wren_q;
    mem_addr  = (state_q == FETCH) ? {line_q, cnt_q} : '0;
    commit_en = (state_q == COMMIT);
  end

  assign cache_rdline   = cpu_addr[3];
  assign cache_rdoffset = cpu_addr[2:0];
  assign cache_rdentry  = hit_way;
  assign cache_wrline   = wrline_q;
  assign cache_wroffset = wroffset_q;
  assign cache_wrentry  = wrentry_q;
  assign cache_wren     = wren_q;
  assign cache_wrdata   = wrdata_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

  // Fill datapath: latch the missing line and victim, then register each returned byte for one write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      line_q     <= '0;
      victim_q   <= 1'b0;
      flushed_q  <= 1'b0;
      wren_q     <= 1'b0;
      wrdata_q   <= '0;
      wroffset_q <= '0;
      wrline_q   <= 1'b0;
      wrentry_q  <= 1'b0;
    end else begin
      wren_q <= beat_accept;
      if (start_fill) begin
        cnt_q     <= '0;
        line_q    <= cpu_addr[ADDR_W-1:3];
        victim_q  <= victim;
        flushed_q <= 1'b0;
      end else if (flush) begin
        flushed_q <= 1'b1;
      end
      if (beat_accept) begin
        wrdata_q   <= mem_data;
        wroffset_q <= cnt_q;
        wrline_q   <= line_q[0];
        wrentry_q  <= victim_q;
      end
      if ((state_q == FETCH) && wren_q)
        cnt_q <= cnt_q + 3'd1;
    end
  end

  // Saturating hit/miss statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit && (hit_cnt_q != '1))  hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (start_fill && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

endmodule
